// File: rtl/cpu_ctrl_fsm_hs_pkg.sv
// rtl/cpu_ctrl_fsm_hs_pkg.sv - state, opcode and strobe encodings shared by the multicycle controller
package cpu_ctrl_pkg;

   typedef enum logic [3:0] {
      S_RESET  = 4'd0,
      S_IF     = 4'd1,
      S_DECODE = 4'd2,
      S_EXEC   = 4'd3,
      S_WB     = 4'd4,
      S_MEM    = 4'd5,
      S_HALT   = 4'd6,
      S_PAUSE  = 4'd7
   } state_e;

   // Multi-cycle instruction classes remembered from DECODE onwards
   typedef enum logic [2:0] {
      C_MOVR = 3'd0,
      C_ALU  = 3'd1,
      C_CMP  = 3'd2,
      C_LDR  = 3'd3,
      C_STR  = 3'd4,
      C_BX   = 3'd5,
      C_BLX  = 3'd6
   } iclass_e;

   localparam logic [2:0] OPC_B    = 3'b001;
   localparam logic [2:0] OPC_BRX  = 3'b010;
   localparam logic [2:0] OPC_LDR  = 3'b011;
   localparam logic [2:0] OPC_STR  = 3'b100;
   localparam logic [2:0] OPC_ALU  = 3'b101;
   localparam logic [2:0] OPC_MOV  = 3'b110;
   localparam logic [2:0] OPC_HALT = 3'b111;

   localparam logic [1:0] OP_MOV_REG = 2'b00;
   localparam logic [1:0] OP_MOV_IMM = 2'b10;
   localparam logic [1:0] OP_CMP     = 2'b01;
   localparam logic [1:0] OP_BX      = 2'b00;
   localparam logic [1:0] OP_BLX     = 2'b10;
   localparam logic [1:0] OP_BL      = 2'b11;

   localparam logic [1:0] MEM_NONE  = 2'b00;
   localparam logic [1:0] MEM_READ  = 2'b10;
   localparam logic [1:0] MEM_WRITE = 2'b01;

   localparam logic [1:0] PC_INC    = 2'b00;
   localparam logic [1:0] PC_BRANCH = 2'b01;
   localparam logic [1:0] PC_REG    = 2'b10;
   localparam logic [1:0] PC_LINK   = 2'b11;

   localparam logic [2:0] REG_RN = 3'b100;
   localparam logic [2:0] REG_RD = 3'b010;
   localparam logic [2:0] REG_RM = 3'b001;

   localparam logic [3:0] VSEL_PC     = 4'b1000;
   localparam logic [3:0] VSEL_SXIMM8 = 4'b0100;
   localparam logic [3:0] VSEL_MDATA  = 4'b0010;
   localparam logic [3:0] VSEL_C      = 4'b0001;

endpackage

// File: rtl/cpu_ctrl_fsm_hs_if.sv
// rtl/cpu_ctrl_fsm_hs_if.sv - ready-handshake memory port between controller and memory
interface cpu_ctrl_fsm_hs_if;
   logic [1:0] mem_cmd;
   logic       addr_sel;
   logic       mem_ready;

   modport master (output mem_cmd, output addr_sel, input mem_ready);
   modport slave  (input mem_cmd, input addr_sel, output mem_ready);
endinterface

// File: rtl/cpu_ctrl_fsm_hs_mem_wait_timer.sv
// rtl/cpu_ctrl_fsm_hs_mem_wait_timer.sv - wait-state counter with bus-error timeout compare
module mem_wait_timer #(
   parameter int MEM_TIMEOUT = 16
) (
   input  logic clk,
   input  logic reset,
   input  logic clear,
   input  logic busy,
   output logic expired
);
   localparam int CNT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;

   logic [CNT_W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clear) begin
         cnt_d = '0;
      end else if (busy) begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   // Expiry fires on the wait cycle that would bring the count up to the limit
   generate
      if (MEM_TIMEOUT == 0) begin : g_no_limit
         assign expired = 1'b0;
      end else begin : g_limit
         localparam logic [CNT_W-1:0] LIMIT = CNT_W'(MEM_TIMEOUT - 1);
         assign expired = busy && (cnt_q == LIMIT);
      end
   endgenerate
endmodule

// File: rtl/cpu_ctrl_fsm_hs.sv
// rtl/cpu_ctrl_fsm_hs.sv - multicycle control FSM with ready-handshake memory and bus timeout
// Optional single-step PAUSE state enabled by CPU_CTRL_STEP_EN.
module cpu_ctrl_fsm_hs
   import cpu_ctrl_pkg::*;
#(
   parameter int MEM_TIMEOUT = 16,
   parameter int STATE_W     = 4
) (
   input  logic             clk,
   input  logic             reset,
`ifdef CPU_CTRL_STEP_EN
   input  logic             step_en,
   input  logic             step,
`endif
   input  logic [2:0]       opcode,
   input  logic [1:0]       op,
   cpu_ctrl_fsm_hs_if.master mem,
   output logic             pc_reset,
   output logic             pc_load,
   output logic             ir_load,
   output logic             write,
   output logic             loada,
   output logic             loadb,
   output logic             loadc,
   output logic             loads,
   output logic             loadm,
   output logic             asel,
   output logic             bsel,
   output logic             csel,
   output logic [1:0]       pc_sel,
   output logic [2:0]       reg_w_sel,
   output logic [2:0]       reg_a_sel,
   output logic [2:0]       reg_b_sel,
   output logic [3:0]       vsel,
   output logic             halt,
   output logic             illegal,
   output logic             bus_err,
   output logic             instr_retired
);
   localparam logic [STATE_W-1:0] ST_RESET  = STATE_W'(S_RESET);
   localparam logic [STATE_W-1:0] ST_IF     = STATE_W'(S_IF);
   localparam logic [STATE_W-1:0] ST_DECODE = STATE_W'(S_DECODE);
   localparam logic [STATE_W-1:0] ST_EXEC   = STATE_W'(S_EXEC);
   localparam logic [STATE_W-1:0] ST_WB     = STATE_W'(S_WB);
   localparam logic [STATE_W-1:0] ST_MEM    = STATE_W'(S_MEM);
   localparam logic [STATE_W-1:0] ST_HALT   = STATE_W'(S_HALT);
`ifdef CPU_CTRL_STEP_EN
   localparam logic [STATE_W-1:0] ST_PAUSE  = STATE_W'(S_PAUSE);
`endif

   logic [STATE_W-1:0] state_q, state_d;
   iclass_e            cls_q, cls_d;
   logic               illegal_q, illegal_d;
   logic               bus_err_q, bus_err_d;
   logic               wait_busy, wait_clear, expired;

   assign wait_busy  = ((state_q == ST_IF) || (state_q == ST_MEM)) && !mem.mem_ready;
   assign wait_clear = (state_d != state_q);

   mem_wait_timer #(.MEM_TIMEOUT(MEM_TIMEOUT)) u_timer (
      .clk     (clk),
      .reset   (reset),
      .clear   (wait_clear),
      .busy    (wait_busy),
      .expired (expired)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q   <= ST_RESET;
         cls_q     <= C_MOVR;
         illegal_q <= 1'b0;
         bus_err_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         cls_q     <= cls_d;
         illegal_q <= illegal_d;
         bus_err_q <= bus_err_d;
      end
   end

   always_comb begin
      state_d   = ST_RESET;
      cls_d     = cls_q;
      illegal_d = illegal_q;
      bus_err_d = bus_err_q;
      case (state_q)
         ST_RESET: state_d = ST_IF;
         ST_IF: begin
            if (mem.mem_ready) begin
               state_d = ST_DECODE;
            end else if (expired) begin
               state_d   = ST_HALT;
               bus_err_d = 1'b1;
            end else begin
               state_d = ST_IF;
            end
         end
         ST_DECODE: begin
            state_d = ST_EXEC;
            case (opcode)
               OPC_HALT: state_d = ST_HALT;
               OPC_MOV: begin
                  if (op == OP_MOV_IMM) begin
                     state_d = ST_IF;
                  end else if (op == OP_MOV_REG) begin
                     cls_d = C_MOVR;
                  end else begin
                     state_d   = ST_HALT;
                     illegal_d = 1'b1;
                  end
               end
               OPC_ALU: cls_d = (op == OP_CMP) ? C_CMP : C_ALU;
               OPC_LDR: cls_d = C_LDR;
               OPC_STR: cls_d = C_STR;
               OPC_B:   state_d = ST_IF;
               OPC_BRX: begin
                  if (op == OP_BL) begin
                     state_d = ST_IF;
                  end else if (op == OP_BX) begin
                     cls_d = C_BX;
                  end else if (op == OP_BLX) begin
                     cls_d = C_BLX;
                  end else begin
                     state_d   = ST_HALT;
                     illegal_d = 1'b1;
                  end
               end
               default: begin
                  state_d   = ST_HALT;
                  illegal_d = 1'b1;
               end
            endcase
         end
         ST_EXEC: begin
            case (cls_q)
               C_CMP, C_BX:  state_d = ST_IF;
               C_LDR, C_STR: state_d = ST_MEM;
               default:      state_d = ST_WB;
            endcase
         end
         ST_WB: state_d = ST_IF;
         ST_MEM: begin
            if (mem.mem_ready) begin
               state_d = ST_IF;
            end else if (expired) begin
               state_d   = ST_HALT;
               bus_err_d = 1'b1;
            end else begin
               state_d = ST_MEM;
            end
         end
         ST_HALT: state_d = ST_HALT;
`ifdef CPU_CTRL_STEP_EN
         ST_PAUSE: state_d = step ? ST_IF : ST_PAUSE;
`endif
         default: state_d = ST_RESET;
      endcase
`ifdef CPU_CTRL_STEP_EN
      // Single-step: every fresh entry into fetch is parked in PAUSE first
      if (step_en && (state_d == ST_IF) && (state_q != ST_IF) && (state_q != ST_PAUSE)) begin
         state_d = ST_PAUSE;
      end
`endif
   end

   always_comb begin
      pc_reset      = 1'b0;
      pc_load       = 1'b0;
      ir_load       = 1'b0;
      write         = 1'b0;
      loada         = 1'b0;
      loadb         = 1'b0;
      loadc         = 1'b0;
      loads         = 1'b0;
      loadm         = 1'b0;
      asel          = 1'b0;
      bsel          = 1'b0;
      csel          = 1'b0;
      pc_sel        = PC_INC;
      mem.mem_cmd   = MEM_NONE;
      mem.addr_sel  = 1'b0;
      reg_w_sel     = 3'b000;
      reg_a_sel     = 3'b000;
      reg_b_sel     = 3'b000;
      vsel          = 4'b0000;
      halt          = 1'b0;
      instr_retired = 1'b0;
      illegal       = illegal_q;
      bus_err       = bus_err_q;
      // Strobes are forced low the instant reset asserts, independent of clk
      if (reset) begin
         case (state_q)
            ST_RESET: begin
               pc_reset = 1'b1;
               pc_load  = 1'b1;
            end
            ST_IF: begin
               mem.addr_sel = 1'b1;
               mem.mem_cmd  = MEM_READ;
               pc_load      = mem.mem_ready;
               ir_load      = mem.mem_ready;
            end
            ST_DECODE: begin
               case (opcode)
                  OPC_MOV: begin
                     if (op == OP_MOV_IMM) begin
                        reg_w_sel     = REG_RN;
                        write         = 1'b1;
                        vsel          = VSEL_SXIMM8;
                        instr_retired = 1'b1;
                     end else if (op == OP_MOV_REG) begin
                        reg_b_sel = REG_RM;
                        loadb     = 1'b1;
                     end
                  end
                  OPC_ALU: begin
                     reg_a_sel = REG_RN;
                     reg_b_sel = REG_RM;
                     loada     = 1'b1;
                     loadb     = 1'b1;
                  end
                  OPC_LDR: begin
                     reg_a_sel = REG_RN;
                     loada     = 1'b1;
                  end
                  OPC_STR: begin
                     reg_a_sel = REG_RN;
                     reg_b_sel = REG_RD;
                     loada     = 1'b1;
                     loadb     = 1'b1;
                  end
                  OPC_B: begin
                     pc_sel        = PC_BRANCH;
                     pc_load       = 1'b1;
                     instr_retired = 1'b1;
                  end
                  OPC_BRX: begin
                     if (op == OP_BL) begin
                        pc_sel        = PC_LINK;
                        pc_load       = 1'b1;
                        reg_w_sel     = REG_RN;
                        write         = 1'b1;
                        vsel          = VSEL_PC;
                        instr_retired = 1'b1;
                     end else if ((op == OP_BX) || (op == OP_BLX)) begin
                        reg_b_sel = REG_RD;
                        loadc     = 1'b1;
                        csel      = 1'b1;
                     end
                  end
                  default: ;
               endcase
            end
            ST_EXEC: begin
               case (cls_q)
                  C_MOVR: begin
                     loadc = 1'b1;
                     asel  = 1'b1;
                  end
                  C_ALU: loadc = 1'b1;
                  C_CMP: begin
                     loads         = 1'b1;
                     instr_retired = 1'b1;
                  end
                  C_LDR: begin
                     loadm = 1'b1;
                     bsel  = 1'b1;
                  end
                  C_STR: begin
                     loadc = 1'b1;
                     loadm = 1'b1;
                     bsel  = 1'b1;
                     csel  = 1'b1;
                  end
                  C_BX: begin
                     pc_sel        = PC_REG;
                     pc_load       = 1'b1;
                     instr_retired = 1'b1;
                  end
                  C_BLX: begin
                     pc_sel  = PC_REG;
                     pc_load = 1'b1;
                  end
                  default: ;
               endcase
            end
            ST_WB: begin
               write         = 1'b1;
               instr_retired = 1'b1;
               if (cls_q == C_BLX) begin
                  reg_w_sel = REG_RN;
                  vsel      = VSEL_PC;
               end else begin
                  reg_w_sel = REG_RD;
                  vsel      = VSEL_C;
               end
            end
            ST_MEM: begin
               mem.mem_cmd   = (cls_q == C_STR) ? MEM_WRITE : MEM_READ;
               instr_retired = mem.mem_ready;
               if ((cls_q != C_STR) && mem.mem_ready) begin
                  reg_w_sel = REG_RD;
                  write     = 1'b1;
                  vsel      = VSEL_MDATA;
               end
            end
            ST_HALT: halt = 1'b1;
            default: ;
         endcase
      end
   end
endmodule

// File: doc/cpu_ctrl_fsm_hs.md
Name: cpu_ctrl_fsm_hs

Overview:
- Next-generation multicycle control FSM for the 16-bit ARM-like datapath.
- Decodes opcode/op and sequences PC, IR, register file, ALU and memory control.
- Generalises the prior controller with a ready-handshake memory port (variable wait states) and a parametrised bus-error timeout.
- Illegal encodings stop the core in HALT with an error flag instead of resetting it. Sits between the instruction register decoder and the datapath/memory.

Parameters:
MEM_TIMEOUT, 16, max cycles a memory state waits for mem_ready before bus error; 0 = wait forever
STATE_W, 4, state register width

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-low
opcode  in  3  IR[15:13]
op  in  2  IR[12:11]
mem_ready  in  1  memory completes current mem_cmd this cycle
pc_reset, pc_load, ir_load, addr_sel, write, loada, loadb, loadc, loads, loadm, asel, bsel, csel  out  1 each  datapath strobes
pc_sel  out  2  00 pc+1, 01 branch target, 10 register, 11 link-branch
mem_cmd  out  2  00 none, 10 read, 01 write
reg_w_sel, reg_a_sel, reg_b_sel  out  3 each  one-hot: 100 Rn, 010 Rd, 001 Rm
vsel  out  4  one-hot writeback source: 1000 pc, 0100 sximm8, 0010 mdata, 0001 C
halt  out  1  core stopped (HALT state)
illegal  out  1  sticky: halted on undefined encoding
bus_err  out  1  sticky: halted on memory timeout
instr_retired  out  1  one-cycle pulse when an instruction completes

Behaviour:
- While reset low: state=RESET, every output 0, wait counter 0, illegal=bus_err=0.
- RESET (one cycle after release): pc_reset=pc_load=1 -> IF.
- IF: addr_sel=1, mem_cmd=10; pc_load=ir_load=mem_ready; stay until mem_ready -> DECODE.
- DECODE, legal encodings:
  - 111_xx -> HALT.
  - MOV imm 110_10: reg_w_sel=100, write=1, vsel=0100, retire -> IF.
  - MOV reg 110_00: reg_b_sel=001, loadb=1 -> EXEC (loadc, asel) -> WB (reg_w_sel=010, write, vsel=0001, retire) -> IF.
  - ALU 101_xx: reg_a_sel=100, reg_b_sel=001, loada=loadb=1 -> EXEC. CMP (op=01) asserts loads and retires -> IF; ADD/AND/MVN assert loadc -> WB as MOV reg -> IF.
  - LDR 011_xx: reg_a_sel=100, loada -> EXEC (loadm, bsel) -> MEM: addr_sel=0, mem_cmd=10, and when mem_ready: reg_w_sel=010, write=1, vsel=0010, retire -> IF.
  - STR 100_xx: reg_a_sel=100, reg_b_sel=010, loada, loadb -> EXEC (loadc, loadm, bsel, csel) -> MEM: mem_cmd=01 until mem_ready, retire -> IF.
  - B-cond 001_xx: pc_sel=01, pc_load=1, retire -> IF.
  - BL 010_11: pc_sel=11, pc_load=1, reg_w_sel=100, write, vsel=1000, retire -> IF.
  - BX 010_00 / BLX 010_10: reg_b_sel=010, loadc, csel -> EXEC (pc_sel=10, pc_load). BX retires -> IF; BLX -> WB (reg_w_sel=100, write, vsel=1000, retire) -> IF.
- Any other {opcode,op} in DECODE, including 110_01, 110_11 and 010_01: illegal<=1 -> HALT.
- HALT: halt=1, absorbing until reset. All other strobes 0.
- Wait counter:
  - Clears on entry to IF or MEM; increments each cycle mem_ready=0 in those states.
  - If MEM_TIMEOUT!=0 and counter reaches MEM_TIMEOUT with mem_ready still 0: bus_err<=1, mem_cmd drops next cycle, -> HALT.
  - mem_ready=1 on the same edge the limit is reached counts as success.
- mem_ready is ignored outside IF and MEM.
- mem_cmd is stable from the first wait cycle until the mem_ready cycle.
- Reset assertion mid-MEM aborts immediately; outputs go 0 asynchronously.
- Unreachable state encodings -> RESET.

Optional Feature:
CPU_CTRL_STEP_EN
- Defined: adds inputs step_en and step.
- With step_en=1, every transition that would enter IF enters PAUSE instead (all strobes 0). PAUSE -> IF on the first cycle with step=1.
- step_en=0 behaves identically to the undefined build.
- Undefined: no ports, no PAUSE state.

Decomposition:
- Package cpu_ctrl_pkg: state enum, opcode/op encodings, MEM_NONE/READ/WRITE, one-hot REG_RN/RD/RM, VSEL_* constants.
- Sub-module mem_wait_timer: counter plus timeout compare, parametrised by MEM_TIMEOUT, with inputs clear and busy and output expired.

Test Plan:
- Reset low 3 cycles then high, mem_ready=1 -> all outputs 0 during reset; cycle 1 pc_reset=pc_load=1; cycle 2 IF with ir_load=1.
- MOV R0,#5 with mem_ready delayed 3 cycles in IF -> mem_cmd=10 held 4 cycles, ir_load only in the 4th; DECODE write=1, vsel=0100, instr_retired=1.
- LDR, mem_ready low 2 cycles in MEM -> write=1 and vsel=0010 only in the ready cycle; exactly one retire pulse.
- MEM_TIMEOUT=4, STR, mem_ready held 0 -> bus_err=1 and halt=1 after 4 wait cycles; mem_cmd returns to 00.
- Opcode/op 110_01 -> illegal=1, halt=1, no write; stays halted until reset, then illegal=0.
- Reset asserted during LDR MEM wait -> outputs 0 in the same cycle without waiting for clk; restart fetches from PC 0.
